// File: rtl/sram_controller.sv
// sram_controller: memory-stage bridge from 32-bit load/store requests to a
// 16-bit asynchronous SRAM. Each access moves two halfwords (low then high),
// waits two cycles, then reports completion through ready.
module sram_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    typedef enum logic [2:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        WAIT1,
        WAIT2,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] read_data_q, read_data_d;
    logic [17:0] addr_q, addr_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;

    logic [16:0] req_word;
    logic        unused_addr_bits;

    // Word index of (address - 1024): the base has no bits below 10, so
    // bits [18:2] of the offset equal address[18:2] - 256 modulo 2^17.
    assign req_word         = address[18:2] - 17'd256;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    // Next-state, capture and registered SRAM strobe computation
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        read_data_d = read_data_q;
        addr_d      = '0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    state_d  = ACC_LO;
                    is_wr_d  = wr_en;
                    word_d   = req_word;
                    wdata_d  = write_data;
                    addr_d   = {req_word, 1'b0};
                    we_n_d   = ~wr_en;
                    oe_n_d   = wr_en;
                    dq_out_d = wr_en ? write_data[15:0] : '0;
                    dq_oe_d  = wr_en;
                end
            end
            ACC_LO: begin
                state_d  = ACC_HI;
                if (!is_wr_q) rbuf_d[15:0] = SRAM_DQ;
                addr_d   = {word_q, 1'b1};
                we_n_d   = ~is_wr_q;
                oe_n_d   = is_wr_q;
                dq_out_d = is_wr_q ? wdata_q[31:16] : '0;
                dq_oe_d  = is_wr_q;
            end
            ACC_HI: begin
                state_d = WAIT1;
                if (!is_wr_q) rbuf_d[31:16] = SRAM_DQ;
            end
            WAIT1: state_d = WAIT2;
            WAIT2: begin
                state_d = DONE;
                if (!is_wr_q) read_data_d = rbuf_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared by rst low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            read_data_q <= read_data_d;
            addr_q      <= addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign ready     = (state_q == DONE) || ((state_q == IDLE) && !(wr_en || rd_en));
    assign read_data = read_data_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scenario tasks drive requests into sram_controller,
// a behavioural SRAM answers on the data bus, and expected load results are
// queued at issue and compared when the controller reports completion.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    logic [31:0] rd_exp_q [$];
    logic [31:0] last_read;

    logic        probe_en;
    logic [15:0] probe_val;
    logic        model_drv;
    logic [15:0] model_val;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: drives the bus while output-enabled, stores on WE_N low
    assign model_drv = !SRAM_OE_N && SRAM_WE_N;
    assign model_val = mem[SRAM_ADDR[7:0]];
    assign SRAM_DQ   = model_drv ? model_val : 'z;
    // Probe driver: a known pattern that only survives if nobody else drives
    assign SRAM_DQ   = probe_en ? probe_val : 'z;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
        end
    end

    task automatic init_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h1000 + 16'(i);
        last_read = '0;
    endtask

    // One full access from request (cycle 0) to completion (cycle 5)
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data, input bit corrupt);
        logic [31:0] off;
        logic [16:0] word;
        logic [17:0] a_lo, a_hi, exp_addr;
        logic        is_wr, act, exp_we, exp_oe, exp_rdy;
        logic [15:0] exp_dq;
        logic [31:0] exp_rd;
        off   = addr - 32'd1024;
        word  = off[18:2];
        a_lo  = {word, 1'b0};
        a_hi  = {word, 1'b1};
        is_wr = wr;
        if (is_wr) begin
            ref_mem[a_lo[7:0]] = data[15:0];
            ref_mem[a_hi[7:0]] = data[31:16];
        end else begin
            rd_exp_q.push_back({ref_mem[a_hi[7:0]], ref_mem[a_lo[7:0]]});
        end
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            act      = (c == 1) || (c == 2);
            exp_rdy  = (c == 5);
            exp_addr = (c == 1) ? a_lo : (c == 2) ? a_hi : '0;
            exp_we   = !(act && is_wr);
            exp_oe   = !(act && !is_wr);
            checks++;
            if (ready !== exp_rdy) begin
                errors++; $display("FAIL ready c%0d addr %h: got %b want %b", c, addr, ready, exp_rdy);
            end
            checks++;
            if (SRAM_ADDR !== exp_addr) begin
                errors++; $display("FAIL sram_addr c%0d: got %h want %h", c, SRAM_ADDR, exp_addr);
            end
            checks++;
            if (SRAM_WE_N !== exp_we || SRAM_OE_N !== exp_oe) begin
                errors++; $display("FAIL strobes c%0d: got we_n=%b oe_n=%b want we_n=%b oe_n=%b",
                                   c, SRAM_WE_N, SRAM_OE_N, exp_we, exp_oe);
            end
            if (act && is_wr) begin
                exp_dq = (c == 1) ? data[15:0] : data[31:16];
                checks++;
                if (SRAM_DQ !== exp_dq) begin
                    errors++; $display("FAIL write_dq c%0d: got %h want %h", c, SRAM_DQ, exp_dq);
                end
            end
            if (c == 5 && !is_wr) begin
                checks++;
                if (rd_exp_q.size() == 0) begin
                    errors++; $display("FAIL scoreboard_empty: got read_data %h want queued value", read_data);
                end else begin
                    exp_rd = rd_exp_q.pop_front();
                    if (read_data !== exp_rd) begin
                        errors++; $display("FAIL read_data addr %h: got %h want %h", addr, read_data, exp_rd);
                    end
                    last_read = exp_rd;
                end
            end else begin
                checks++;
                if (read_data !== last_read) begin
                    errors++; $display("FAIL read_data_hold c%0d: got %h want %h", c, read_data, last_read);
                end
            end
            @(posedge clk); #1;
            if (corrupt && c == 0) begin
                address = '1; write_data = '1;
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 || SRAM_ADDR !== 18'd0) begin
                errors++; $display("FAIL idle: got ready=%b we_n=%b oe_n=%b addr=%h want 1 1 1 0",
                                   ready, SRAM_WE_N, SRAM_OE_N, SRAM_ADDR);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        probe_en = 1'b1; probe_val = 16'h5A5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (read_data !== 32'd0 || SRAM_ADDR !== 18'd0 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1) begin
            errors++; $display("FAIL reset_outputs: got rd=%h addr=%h we_n=%b oe_n=%b want 0 0 1 1",
                               read_data, SRAM_ADDR, SRAM_WE_N, SRAM_OE_N);
        end
        checks++;
        if (SRAM_DQ !== 16'h5A5A) begin
            errors++; $display("FAIL reset_dq_released: got %h want 5a5a", SRAM_DQ);
        end
        checks++;
        if (SRAM_CE_N !== 1'b0 || SRAM_UB_N !== 1'b0 || SRAM_LB_N !== 1'b0) begin
            errors++; $display("FAIL const_strobes: got ce=%b ub=%b lb=%b want 0 0 0", SRAM_CE_N, SRAM_UB_N, SRAM_LB_N);
        end
        rst = 1'b1; probe_en = 1'b0;
        init_ref();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL ready_idle: got %b want 1", ready);
        end
        rd_en = 1'b1; #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL ready_comb_request: got %b want 0", ready);
        end
        rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        do_txn(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_read();
        do_txn(1'b0, 1'b1, 32'd1032, '0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_write_priority();
        do_txn(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
        idle_cycles(1);
        checks++;
        if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin
            errors++; $display("FAIL priority_mem: got %h%h want 12345678", mem[1], mem[0]);
        end
    endtask

    task automatic test_input_change();
        do_txn(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 1'b1);
        idle_cycles(1);
        do_txn(1'b0, 1'b1, 32'd1036, '0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_address_map();
        do_txn(1'b0, 1'b1, 32'h80000403, '0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        do_txn(1'b0, 1'b1, 32'd1024, '0, 1'b0);
        do_txn(1'b0, 1'b1, 32'd1028, '0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_access();
        wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
        @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (SRAM_WE_N !== 1'b0) begin
            errors++; $display("FAIL abort_precondition: got we_n=%b want 0", SRAM_WE_N);
        end
        rst = 1'b0; #1;
        wr_en = 1'b0; probe_en = 1'b1; probe_val = 16'hA5A5; #1;
        checks++;
        if (SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 || SRAM_ADDR !== 18'd0) begin
            errors++; $display("FAIL abort_strobes: got we_n=%b oe_n=%b addr=%h want 1 1 0",
                               SRAM_WE_N, SRAM_OE_N, SRAM_ADDR);
        end
        checks++;
        if (SRAM_DQ !== 16'hA5A5) begin
            errors++; $display("FAIL abort_dq_released: got %h want a5a5", SRAM_DQ);
        end
        checks++;
        if (read_data !== 32'd0) begin
            errors++; $display("FAIL abort_read_data: got %h want 0", read_data);
        end
        @(negedge clk);
        rst = 1'b1; probe_en = 1'b0;
        init_ref();
        idle_cycles(4);
        do_txn(1'b0, 1'b1, 32'd1040, '0, 1'b0);
        idle_cycles(1);
    endtask

    initial begin
        probe_en = 1'b0; probe_val = '0;
        test_reset();
        test_write();
        test_read();
        test_write_priority();
        test_input_change();
        test_address_map();
        test_back_to_back();
        test_reset_mid_access();
        checks++;
        if (rd_exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", rd_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 wr_en  input  1  memory-stage write request.
REQ-004 rd_en  input  1  memory-stage read request.
REQ-005 address  input  32  byte address from ALU result; data region base 1024.
REQ-006 write_data  input  32  store data (Rm value).
REQ-007 read_data  output  32  load result.
REQ-008 ready  output  1  1 = no access pending; 0 stalls the pipeline (IF, IF/ID, ID/EXE, EXE/MEM, MEM/WB freeze).
REQ-009 SRAM_DQ  inout  16  SRAM data bus.
REQ-010 SRAM_ADDR  output  18  SRAM halfword address.
REQ-011 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM strobes.

Function
REQ-012 FSM states: IDLE, ACC_LO, ACC_HI, WAIT1, WAIT2, DONE.
REQ-013 Transitions: IDLE->ACC_LO when wr_en|rd_en; else stay IDLE; ACC_LO->ACC_HI->WAIT1->WAIT2->DONE->IDLE unconditionally.
REQ-014 Acceptance in IDLE registers op (write if wr_en, else read), address, write_data; inputs are ignored in all other states.
REQ-015 wr_en and rd_en both 1: write wins.
REQ-016 ready = 1 in DONE; in IDLE ready = ~(wr_en|rd_en) (combinational, same cycle as request); 0 in all other states.
REQ-017 Latency: request visible in cycle 0 -> ready=1 in cycle 5; pipeline advances on that edge.
REQ-018 Address map: offset = address - 1024; word = offset[18:2]; ACC_LO drives SRAM_ADDR = {word,0}, ACC_HI drives {word,1}; offset[1:0] and bits above 18 ignored; SRAM_ADDR = 0 in all other states.
REQ-019 Write: ACC_LO drives SRAM_DQ = write_data[15:0] with SRAM_WE_N=0; ACC_HI drives write_data[31:16] with SRAM_WE_N=0.
REQ-020 SRAM_DQ is high-Z except in ACC_LO/ACC_HI of a write.
REQ-021 Read: SRAM_OE_N=0 in ACC_LO/ACC_HI; DQ sampled at end of ACC_LO into low half, at end of ACC_HI into high half of an internal register.
REQ-022 read_data updates only at DONE entry of a read; holds its value through writes and idle cycles.
REQ-023 SRAM_WE_N = 1 and SRAM_OE_N = 1 outside REQ-019/REQ-021 conditions; SRAM_CE_N, SRAM_UB_N, SRAM_LB_N constant 0.
REQ-024 Back-to-back requests: a request present in the cycle after DONE is accepted normally; no bubble beyond the IDLE cycle.

Reset
REQ-025 rst=0 asynchronously forces IDLE, read_data=0, captured registers=0, SRAM_DQ high-Z, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0.
REQ-026 Reset mid-access aborts it; no further SRAM strobes; ready follows REQ-016 from IDLE after release.

Verification
REQ-027 Write 0xDEADBEEF to 1032 -> ready=0 cycles 0-4, ready=1 cycle 5; SRAM_ADDR=4 with DQ=0xBEEF, WE_N=0, then SRAM_ADDR=5 with DQ=0xDEAD, WE_N=0.
REQ-028 Read 1032 after REQ-027 (SRAM model) -> read_data=0xDEADBEEF at cycle 5, OE_N=0 in exactly two cycles, DQ never driven by DUT.
REQ-029 wr_en=rd_en=1, address 1024, data 0x12345678 -> write performed at SRAM_ADDR 0/1; read_data unchanged.
REQ-030 Change address/write_data to 0xFFFFFFFF during ACC_HI -> transferred values remain the captured ones.
REQ-031 rst=0 during ACC_LO of a write -> WE_N=1 and DQ high-Z immediately; after release with no request, ready=1 and SRAM_ADDR=0.
REQ-032 Two consecutive reads 1024, 1028 -> second accepted one cycle after first DONE; ready pattern 0,0,0,0,0,1,0,0,0,0,0,1.
